// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Start/done handshake; results held in output registers until the next completion.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one full-adder step per clock on the shifted operands
// DONE  | result valid, done high for this cycle; start re-launches
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic             carry_next;
  logic             b_inv;
  logic             sum_bit;
  logic [CNT_W-1:0] bits_left;
  logic             last_bit;

  // Bit counter runs down; terminal count marks the MSB step.
  assign last_bit = (state_q == RUN) && (bits_left == '0);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (bits_left == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One full-adder cell on the inverted subtrahend bit.
  always_comb begin
    b_inv      = ~b_sh[0];
    sum_bit    = a_sh[0] ^ b_inv ^ carry_q;
    carry_next = (a_sh[0] & b_inv) | (a_sh[0] & carry_q) | (b_inv & carry_q);
    res_next   = {sum_bit, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry_q    <= 1'b0;
      bits_left  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= last_bit;

      if (accept) begin
        a_sh      <= a;
        b_sh      <= b;
        res_sh    <= '0;
        carry_q   <= 1'b1;
        bits_left <= CNT_LAST;
      end else if (state_q == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        res_sh  <= res_next;
        carry_q <= carry_next;
        if (bits_left != '0) begin
          bits_left <= bits_left - CNT_ONE;
        end
        // carry_q here is still the carry into the MSB cell.
        if (last_bit) begin
          diff       <= res_next;
          borrow_out <= ~carry_next;
          overflow   <= carry_q ^ carry_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for handshake/corner cases
// and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4, ovf4;
  logic [3:0] diff4;

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
    .borrow_out(borrow8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4),
    .borrow_out(borrow4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation and wait (bounded) for the done cycle.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     output int busy_cycles, output bit timed_out);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    busy_cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        timed_out = 1'b0;
        break;
      end
      if (busy8) busy_cycles++;
      tick();
    end
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, output bit timed_out);
    a4 = av; b4 = bv; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy8, done8, diff8, borrow8, ovf8);
    end
    n_cmp++;
    if ({busy4, done4, diff4, borrow4, ovf4} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset4: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy4, done4, diff4, borrow4, ovf4);
    end
  endtask

  task automatic test_basic();
    int bc;
    bit to;
    op8(8'd100, 8'd37, bc, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL basic_timeout: no done within 20 cycles");
    end
    n_cmp++;
    if (bc !== 8) begin
      n_bad++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
    end
    n_cmp++;
    if ({busy8, diff8, borrow8, ovf8} !== {1'b0, 8'h3F, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result: got busy=%b diff=%h borrow=%b ovf=%b, want 0 3f 0 0",
               busy8, diff8, borrow8, ovf8);
    end
    tick();
    n_cmp++;
    if ({done8, busy8, diff8} !== {1'b0, 1'b0, 8'h3F}) begin
      n_bad++;
      $display("FAIL basic_after_done: got done=%b busy=%b diff=%h, want 0 0 3f",
               done8, busy8, diff8);
    end
  endtask

  task automatic test_corners();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic [7:0] vd [5];
    logic       vbr[5];
    logic       vov[5];
    int bc;
    bit to;
    va[0] = 8'd5;   vb[0] = 8'd9;   vd[0] = 8'hFC; vbr[0] = 1; vov[0] = 0;
    va[1] = 8'h80;  vb[1] = 8'h01;  vd[1] = 8'h7F; vbr[1] = 0; vov[1] = 1;
    va[2] = 8'h7F;  vb[2] = 8'hFF;  vd[2] = 8'h80; vbr[2] = 1; vov[2] = 1;
    va[3] = 8'h5A;  vb[3] = 8'h5A;  vd[3] = 8'h00; vbr[3] = 0; vov[3] = 0;
    va[4] = 8'h00;  vb[4] = 8'h80;  vd[4] = 8'h80; vbr[4] = 1; vov[4] = 1;
    for (int k = 0; k < 5; k++) begin
      op8(va[k], vb[k], bc, to);
      n_cmp++;
      if (to || diff8 !== vd[k] || borrow8 !== vbr[k] || ovf8 !== vov[k]) begin
        n_bad++;
        $display("FAIL corner%0d: %h-%h got diff=%h borrow=%b ovf=%b timeout=%b, want %h %b %b",
                 k, va[k], vb[k], diff8, borrow8, ovf8, to, vd[k], vbr[k], vov[k]);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored_and_abort();
    bit to;
    int dones;
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    n_cmp++;
    if (to || diff8 !== 8'h55 || borrow8 !== 1'b0 || ovf8 !== 1'b1) begin
      n_bad++;
      $display("FAIL start_ignored: got diff=%h borrow=%b ovf=%b timeout=%b, want 55 0 1",
               diff8, borrow8, ovf8, to);
    end
    tick();

    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_busy_before: got busy=%b, want 1", busy8);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
      n_bad++;
      $display("FAIL abort_reset: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy8, done8, diff8, borrow8, ovf8);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) dones++;
    end
    n_cmp++;
    if (dones !== 0 || diff8 !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d active cycles diff=%h, want 0 and 00", dones, diff8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [7:0] pd [4];
    logic       pbr[4];
    logic       pov[4];
    int bc;
    bit to;
    pa[0] = 8'd200; pb[0] = 8'd13;  pd[0] = 8'hBB; pbr[0] = 0; pov[0] = 0;
    pa[1] = 8'd3;   pb[1] = 8'd250; pd[1] = 8'h09; pbr[1] = 1; pov[1] = 0;
    pa[2] = 8'h80;  pb[2] = 8'h7F;  pd[2] = 8'h01; pbr[2] = 0; pov[2] = 1;
    pa[3] = 8'h40;  pb[3] = 8'hC0;  pd[3] = 8'h80; pbr[3] = 1; pov[3] = 1;
    a8 = pa[0]; b8 = pb[0]; start8 = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      a8 = 8'hFF; b8 = 8'h00;
      bc = 0;
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (done8) begin
          to = 1'b0;
          break;
        end
        if (busy8) bc++;
        tick();
      end
      n_cmp++;
      if (to || bc !== 8) begin
        n_bad++;
        $display("FAIL b2b_period%0d: got %0d busy cycles timeout=%b, want 8", k, bc, to);
      end
      n_cmp++;
      if (diff8 !== pd[k] || borrow8 !== pbr[k] || ovf8 !== pov[k]) begin
        n_bad++;
        $display("FAIL b2b_result%0d: got diff=%h borrow=%b ovf=%b, want %h %b %b",
                 k, diff8, borrow8, ovf8, pd[k], pbr[k], pov[k]);
      end
      if (k < 3) begin
        a8 = pa[k+1]; b8 = pb[k+1];
      end else begin
        start8 = 1'b0;
      end
      tick();
      n_cmp++;
      if (done8 !== 1'b0 || diff8 !== pd[k] || busy8 !== (k < 3)) begin
        n_bad++;
        $display("FAIL b2b_hold%0d: got done=%b busy=%b diff=%h, want 0 %b %h",
                 k, done8, busy8, diff8, (k < 3), pd[k]);
      end
    end
  endtask

  task automatic test_sweep_w4();
    bit to;
    int sa, sb, sd;
    logic [3:0] ed;
    logic       ebr, eov;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        op4(ai[3:0], bi[3:0], to);
        ed  = 4'((ai - bi) & 15);
        ebr = (ai < bi);
        sa  = (ai > 7) ? ai - 16 : ai;
        sb  = (bi > 7) ? bi - 16 : bi;
        sd  = sa - sb;
        eov = (sd > 7) || (sd < -8);
        n_cmp++;
        if (to || diff4 !== ed || borrow4 !== ebr || ovf4 !== eov) begin
          n_bad++;
          $display("FAIL sweep4 %0d-%0d: got diff=%h borrow=%b ovf=%b timeout=%b, want %h %b %b",
                   ai, bi, diff4, borrow4, ovf4, to, ed, ebr, eov);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored_and_abort();
    test_back_to_back();
    test_sweep_w4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
